i2s_rx_deserializer: RTL

// - Upstream front end of the audio filter chain: receives the ADC I2S stream (sclk/ws/sd),

---
 rtl/i2s_rx_deserializer_if.sv | 25 ++
 rtl/i2s_rx_deserializer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_deserializer_if.sv
// I2S receive bundle: serial lines from the ADC and the deserialised sample outputs.
// The deserializer takes the slave modport; the master side drives the I2S lines.
interface i2s_rx_deserializer_if #(
    parameter int unsigned SAMPLE_W = 16
);
    logic                i2s_sclk;
    logic                i2s_ws;
    logic                i2s_sd;
    logic [SAMPLE_W-1:0] left_sample;
    logic [SAMPLE_W-1:0] right_sample;
    logic [SAMPLE_W-1:0] latest_sample;
    logic                sample_valid;
    logic                l_r_clk;
    logic                frame_err;

    modport master (
        output i2s_sclk, i2s_ws, i2s_sd,
        input  left_sample, right_sample, latest_sample, sample_valid, l_r_clk, frame_err
    );

    modport slave (
        input  i2s_sclk, i2s_ws, i2s_sd,
        output left_sample, right_sample, latest_sample, sample_valid, l_r_clk, frame_err
    );
endinterface

// File: rtl/i2s_rx_deserializer.sv
// I2S receiver: synchronises sclk/ws/sd into clk and deserialises MSB-first channel words.
// Optional short-word detection (frame_err) is built only when I2S_FRAME_CHECK_EN is defined.
module i2s_rx_deserializer #(
    parameter int unsigned SAMPLE_W    = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    i2s_rx_deserializer_if.slave  bus
);
    localparam int unsigned      CNT_W    = $clog2(SAMPLE_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_W - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SAMPLE_W);

    typedef enum logic [1:0] {IDLE, SHIFT, PAD} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ws_sync_q, ws_sync_d;
    logic [SYNC_STAGES-1:0] sd_sync_q, sd_sync_d;
    logic                   sclk_q, sclk_d;
    logic                   ws_prev_q, ws_prev_d;
    logic                   ws_seen_q, ws_seen_d;
    state_t                 state_q, state_d;
    logic                   chan_q, chan_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_W-1:0]    shift_q, shift_d;
    logic                   latch_q, latch_d;
    logic                   latch_chan_q, latch_chan_d;
    logic [SAMPLE_W-1:0]    latch_word_q, latch_word_d;
    logic [SAMPLE_W-1:0]    left_q, left_d;
    logic [SAMPLE_W-1:0]    right_q, right_d;
    logic [SAMPLE_W-1:0]    latest_q, latest_d;
    logic                   valid_q, valid_d;
    logic                   out_chan_q, out_chan_d;
    logic                   lr_q, lr_d;
`ifdef I2S_FRAME_CHECK_EN
    logic                   short_q, short_d;
    logic                   frame_err_q, frame_err_d;
`endif

    logic                   sclk_rise;
    logic                   ws_s;
    logic                   sd_s;
    logic                   ws_edge;
    logic [SAMPLE_W-1:0]    shift_in;

    always_comb begin
        sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], bus.i2s_sclk};
        ws_sync_d    = {ws_sync_q[SYNC_STAGES-2:0], bus.i2s_ws};
        sd_sync_d    = {sd_sync_q[SYNC_STAGES-2:0], bus.i2s_sd};
        sclk_d       = sclk_sync_q[SYNC_STAGES-1];
        ws_s         = ws_sync_q[SYNC_STAGES-1];
        sd_s         = sd_sync_q[SYNC_STAGES-1];
        sclk_rise    = sclk_sync_q[SYNC_STAGES-1] & ~sclk_q;
        // The very first rise has no predecessor, so it can never count as a ws edge.
        ws_edge      = sclk_rise & ws_seen_q & (ws_s != ws_prev_q);
        shift_in     = {shift_q[SAMPLE_W-2:0], sd_s};

        ws_prev_d    = sclk_rise ? ws_s : ws_prev_q;
        ws_seen_d    = ws_seen_q | sclk_rise;
        state_d      = state_q;
        chan_d       = chan_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        latch_d      = 1'b0;
        latch_chan_d = latch_chan_q;
        latch_word_d = latch_word_q;
`ifdef I2S_FRAME_CHECK_EN
        short_d      = 1'b0;
`endif

        case (state_q)
            IDLE, PAD: begin
                if (ws_edge) begin
                    chan_d    = ws_s;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        // Last bit completes the word even when ws flips on the same rise.
                        latch_d      = 1'b1;
                        latch_chan_d = chan_q;
                        latch_word_d = shift_in;
                        bit_cnt_d    = FULL_CNT;
                        state_d      = PAD;
                        if (ws_edge) begin
                            chan_d    = ws_s;
                            bit_cnt_d = '0;
                            shift_d   = '0;
                            state_d   = SHIFT;
                        end
                    end else if (ws_edge) begin
                        latch_d      = 1'b1;
                        latch_chan_d = chan_q;
                        latch_word_d = shift_q << (FULL_CNT - bit_cnt_q);
`ifdef I2S_FRAME_CHECK_EN
                        short_d      = 1'b1;
`endif
                        chan_d       = ws_s;
                        bit_cnt_d    = '0;
                        shift_d      = '0;
                    end else begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        left_d     = left_q;
        right_d    = right_q;
        latest_d   = latest_q;
        out_chan_d = out_chan_q;
        valid_d    = latch_q;
        if (latch_q) begin
            latest_d   = latch_word_q;
            out_chan_d = latch_chan_q;
            if (latch_chan_q) right_d = latch_word_q;
            else              left_d  = latch_word_q;
        end
        // l_r_clk trails sample_valid by one clk so the filter only sees stable data.
        lr_d = valid_q ? out_chan_q : lr_q;
`ifdef I2S_FRAME_CHECK_EN
        frame_err_d = latch_q & short_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q  <= '0;
            ws_sync_q    <= '0;
            sd_sync_q    <= '0;
            sclk_q       <= 1'b0;
            ws_prev_q    <= 1'b0;
            ws_seen_q    <= 1'b0;
            state_q      <= IDLE;
            chan_q       <= 1'b0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            latch_q      <= 1'b0;
            latch_chan_q <= 1'b0;
            latch_word_q <= '0;
            left_q       <= '0;
            right_q      <= '0;
            latest_q     <= '0;
            valid_q      <= 1'b0;
            out_chan_q   <= 1'b0;
            lr_q         <= 1'b0;
`ifdef I2S_FRAME_CHECK_EN
            short_q      <= 1'b0;
            frame_err_q  <= 1'b0;
`endif
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            ws_sync_q    <= ws_sync_d;
            sd_sync_q    <= sd_sync_d;
            sclk_q       <= sclk_d;
            ws_prev_q    <= ws_prev_d;
            ws_seen_q    <= ws_seen_d;
            state_q      <= state_d;
            chan_q       <= chan_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            latch_q      <= latch_d;
            latch_chan_q <= latch_chan_d;
            latch_word_q <= latch_word_d;
            left_q       <= left_d;
            right_q      <= right_d;
            latest_q     <= latest_d;
            valid_q      <= valid_d;
            out_chan_q   <= out_chan_d;
            lr_q         <= lr_d;
`ifdef I2S_FRAME_CHECK_EN
            short_q      <= short_d;
            frame_err_q  <= frame_err_d;
`endif
        end
    end

    assign bus.left_sample   = left_q;
    assign bus.right_sample  = right_q;
    assign bus.latest_sample = latest_q;
    assign bus.sample_valid  = valid_q;
    assign bus.l_r_clk       = lr_q;
`ifdef I2S_FRAME_CHECK_EN
    assign bus.frame_err     = frame_err_q;
`else
    assign bus.frame_err     = 1'b0;
`endif
endmodule
